shift_mul_seq: RTL
==================

Name: shift_mul_seq

Overview:
- Sequential shift-and-add multiplier controller that sits around the pipelined 16-bit shifter: it feeds the shifter's (a, distance) inputs and consumes its 32-bit result.
- For each set bit of multiplier b it issues a shift of a by the bit index, then accumulates the returned partial products into a 32-bit product.
- Provides a start/busy/done interface to the surrounding datapath.
- Fixed latency, independent of operand values.

Parameters:
- WIDTH, 16, operand width (a, b, sh_a).
- DIST_W, 4, shift-distance width (log2 WIDTH).
- OUT_W, 32, product / shifter-result width (2*WIDTH).
- SHIFT_LAT, 2, shifter latency in cycles: inputs presented in cycle k produce sh_r valid in cycle k+SHIFT_LAT.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; accepted only in IDLE.
- a  in  WIDTH  multiplicand, sampled when start is accepted.
- b  in  WIDTH  multiplier, sampled when start is accepted.
- busy  out  1  high in ISSUE, DRAIN and DONE.
- done  out  1  one-cycle pulse; product valid this cycle.
- product  out  OUT_W  a*b; holds its value until the next done.
- sh_a  out  WIDTH  operand to the shifter.
- sh_distance  out  DIST_W  shift amount to the shifter.
- sh_r  in  OUT_W  shifter result, SHIFT_LAT cycles after the matching sh_a/sh_distance.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; busy=0, done=0, product=0, sh_a=0, sh_distance=0; accumulator, index and valid delay line cleared. Reset mid-operation aborts it with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE: when start=1. Latch a_reg=a, b_reg=b; set idx=0 and acc=0.
- ISSUE:
  - Lasts exactly WIDTH cycles.
  - Each cycle drive sh_a=a_reg and sh_distance=idx.
  - Push tag b_reg[idx] into the SHIFT_LAT-deep valid delay line.
  - idx++.
  - After the cycle with idx=WIDTH-1, go to DRAIN. idx never wraps inside ISSUE.
- DRAIN: lasts SHIFT_LAT cycles; push 0 tags; sh_a=0, sh_distance=0. Then go to DONE.
- Accumulate, in any state: when the delay-line output tag=1, acc <= acc + sh_r, truncated to OUT_W. No overflow is possible because the max product is 0xFFFE0001.
- DONE: lasts 1 cycle; done=1, product=acc (registered so it is visible in the DONE cycle); next state IDLE.
- Latency: start high in cycle T gives done high in cycle T+WIDTH+SHIFT_LAT+1, i.e. T+19 with defaults. This holds regardless of b, including b=0.
- Back-to-back operation: start is ignored in ISSUE, DRAIN and DONE. Earliest next acceptance is the IDLE cycle after DONE, so the start-to-start interval is at least WIDTH+SHIFT_LAT+2 cycles.
- Outside ISSUE, sh_a and sh_distance are driven to 0.
- rst has priority over start in the same cycle.

Decomposition:
- Package shift_mul_pkg:
  - state_t enum {IDLE, ISSUE, DRAIN, DONE}.
  - localparams for WIDTH, DIST_W, OUT_W and default SHIFT_LAT.
- Sub-module valid_delay:
  - Parameterised depth SHIFT_LAT, 1-bit shift register with synchronous clear on rst.
  - Aligns issue tags with sh_r.
- Shifter not instantiated inside; top level connects it.

Test Plan:
The bench drives sh_r from a behavioural shifter model, r = a << distance, with SHIFT_LAT=2 register stages.
1. a=3, b=5, start in cycle T -> busy from T+1; done only in T+19 with product=15; sh_distance counts 0..15 during T+1..T+16.
2. a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; no truncation error.
3. a=0x1234, b=0 -> product=0 and done at T+19; acc never updated. Also a=0, b=0xFFFF -> 0.
4. Start a=3, b=5; re-pulse start with a=9, b=9 at T+5 and T+19 -> both ignored; product=15; busy low at T+20.
5. Start a=100, b=100; assert rst at T+8 -> next cycle busy=0, done=0, product=0, no done pulse. Then start a=7, b=6 -> product=42 at +19.
6. Hold start=1 continuously with a=2, b=9 -> done pulses every 20 cycles, product=18 each time, accepted in the IDLE cycle following DONE.

Source files
------------

// File: rtl/shift_mul_pkg.sv
// shift_mul_pkg: shared widths and FSM state encoding for the shift-and-add multiplier
package shift_mul_pkg;
  localparam int WIDTH = 16;
  localparam int DIST_W = 4;
  localparam int OUT_W = 32;
  localparam int SHIFT_LAT = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/shift_mul_seq_if.sv
// shift_mul_seq_if: start/busy/done request bus plus the shifter operand/result path
interface shift_mul_seq_if #(
  parameter int WIDTH = shift_mul_pkg::WIDTH,
  parameter int DIST_W = shift_mul_pkg::DIST_W,
  parameter int OUT_W = shift_mul_pkg::OUT_W
);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [OUT_W-1:0] product;
  logic [WIDTH-1:0] sh_a;
  logic [DIST_W-1:0] sh_distance;
  logic [OUT_W-1:0] sh_r;
  modport slave (input start, a, b, sh_r, output busy, done, product, sh_a, sh_distance);
  modport master (output start, a, b, sh_r, input busy, done, product, sh_a, sh_distance);
endinterface

// File: rtl/shift_mul_seq_valid_delay.sv
// valid_delay: 1-bit tag delay line that lines issue tags up with the shifter result
module valid_delay #(
  parameter int DEPTH = shift_mul_pkg::SHIFT_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr_q, sr_d;
  always_comb begin
    sr_d = sr_q << 1;
    sr_d[0] = din;
  end
  always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/shift_mul_seq.sv
// shift_mul_seq: fixed-latency shift-and-add multiplier driving an external pipelined shifter
module shift_mul_seq #(
  parameter int WIDTH = shift_mul_pkg::WIDTH,
  parameter int DIST_W = shift_mul_pkg::DIST_W,
  parameter int OUT_W = shift_mul_pkg::OUT_W,
  parameter int SHIFT_LAT = shift_mul_pkg::SHIFT_LAT
) (
  input logic clk,
  input logic rst,
  shift_mul_seq_if.slave bus
);
  import shift_mul_pkg::*;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DIST_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d, product_q, product_d;
  logic tag_in, tag_out;
  valid_delay #(.DEPTH(SHIFT_LAT)) u_valid_delay (
    .clk(clk),
    .rst(rst),
    .din(tag_in),
    .dout(tag_out)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    idx_d = idx_q;
    acc_d = tag_out ? acc_q + bus.sh_r : acc_q;
    product_d = product_q;
    tag_in = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = ISSUE;
        a_d = bus.a;
        b_d = bus.b;
        idx_d = '0;
        acc_d = '0;
      end
      ISSUE: begin
        tag_in = b_q[idx_q];
        idx_d = idx_q + DIST_W'(1);
        if (idx_q == DIST_W'(WIDTH - 1)) begin
          state_d = DRAIN;
          idx_d = '0;
        end
      end
      DRAIN: begin
        idx_d = idx_q + DIST_W'(1);
        // the final partial product lands on this edge, so capture the updated sum
        if (idx_q == DIST_W'(SHIFT_LAT - 1)) begin
          state_d = DONE;
          idx_d = '0;
          product_d = acc_d;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      product_q <= product_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.product = product_q;
  assign bus.sh_a = state_q == ISSUE ? a_q : '0;
  assign bus.sh_distance = state_q == ISSUE ? idx_q : '0;
endmodule
